// File: rtl/ascii_dec_parse.sv
// ascii_dec_parse: serial ASCII-decimal to binary parser.
//   Takes one ASCII character per char_valid/char_ready handshake and
//   accumulates up to MAX_DIGITS decimal digits. A CR or LF terminator
//   publishes the value on val with a one-cycle val_valid pulse. Malformed
//   input pulses err once, then characters are discarded up to the next
//   terminator.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   char_in/char_valid  ASCII character and its valid strobe
//   char_ready          low only during the single DONE cycle after a result
//   val/val_valid       last good value (held) and its update pulse
//   err                 one-cycle malformed-number pulse
//   busy                high while a number is being accumulated
// Optional build macro: ASCII_PARSE_NEG_EN adds support for a leading '-'
//   and two's-complement results.
module ascii_dec_parse #(
  parameter int WIDTH      = 12,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  output logic [WIDTH-1:0] val,
  output logic             val_valid,
  output logic             err,
  output logic             busy
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int SW = WIDTH + 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE, DRAIN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] val_nx;
  logic             val_valid_nx, err_nx, busy_nx, ready_nx;

  // character classification
  logic          accept, is_dig, is_term, is_minus, empty_neg, over;
  logic [3:0]    dig;
  logic [SW-1:0] sum, limit;

  assign accept  = char_valid && char_ready;
  assign is_dig  = (char_in >= 8'd48) && (char_in <= 8'd57);
  assign is_term = (char_in == 8'd13) || (char_in == 8'd10);
  assign dig     = char_in[3:0];   // '0'..'9' carry their value in the low nibble
  assign sum     = ({4'b0, acc} * SW'(10)) + {{WIDTH{1'b0}}, dig};
  assign over    = sum > limit;

`ifdef ASCII_PARSE_NEG_EN
  logic neg, neg_nx;
  assign is_minus  = (char_in == 8'd45);
  // negative side of the range reaches one step further than the positive
  assign limit     = neg ? (SW'(1) << (WIDTH-1)) : ((SW'(1) << (WIDTH-1)) - SW'(1));
  // terminator right after a lone '-'
  assign empty_neg = (state == ACCUM) && accept && is_term && (cnt == '0);
`else
  assign is_minus  = 1'b0;
  assign limit     = {4'b0, {WIDTH{1'b1}}};
  assign empty_neg = 1'b0;
`endif

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      val        <= '0;
      val_valid  <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      char_ready <= 1'b1;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      cnt        <= cnt_nx;
      val        <= val_nx;
      val_valid  <= val_valid_nx;
      err        <= err_nx;
      busy       <= busy_nx;
      char_ready <= ready_nx;
    end
  end

`ifdef ASCII_PARSE_NEG_EN
  always_ff @(posedge clk) begin
    if (rst) neg <= 1'b0;
    else     neg <= neg_nx;
  end
`endif

  // next-state and accumulator
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
`ifdef ASCII_PARSE_NEG_EN
    neg_nx   = neg;
`endif
    unique case (state)
      IDLE: if (accept) begin
        if (is_dig) begin
          state_nx = ACCUM;
          acc_nx   = {{(WIDTH-4){1'b0}}, dig};
          cnt_nx   = CW'(1);
`ifdef ASCII_PARSE_NEG_EN
          neg_nx   = 1'b0;
`endif
        end else if (is_minus) begin
          state_nx = ACCUM;
          acc_nx   = '0;
          cnt_nx   = '0;
`ifdef ASCII_PARSE_NEG_EN
          neg_nx   = 1'b1;
`endif
        end else if (!is_term) begin
          state_nx = DRAIN;
        end
      end
      ACCUM: if (accept) begin
        if (is_dig) begin
          if (cnt == CW'(MAX_DIGITS) || over) begin
            state_nx = DRAIN;
          end else begin
            acc_nx = sum[WIDTH-1:0];
            cnt_nx = cnt + CW'(1);
          end
        end else if (is_term) begin
          state_nx = empty_neg ? IDLE : DONE;
        end else begin
          state_nx = DRAIN;
        end
      end
      DONE:  state_nx = IDLE;
      DRAIN: if (accept && is_term) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // registered output next values
  always_comb begin
    val_nx       = val;
    val_valid_nx = 1'b0;
    // err fires only on the transition into DRAIN, so draining stays silent
    err_nx       = ((state == IDLE || state == ACCUM) && state_nx == DRAIN) || empty_neg;
    busy_nx      = (state_nx == ACCUM);
    ready_nx     = (state_nx != DONE);
    if (state == ACCUM && state_nx == DONE) begin
      val_valid_nx = 1'b1;
`ifdef ASCII_PARSE_NEG_EN
      val_nx       = neg ? (~acc + WIDTH'(1)) : acc;
`else
      val_nx       = acc;
`endif
    end
  end

endmodule

// File: tb/tb_ascii_dec_parse.sv
module tb_ascii_dec_parse;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_in = 8'd0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [11:0] val;
  logic        val_valid, err, busy;
  int          checks = 0;
  int          errors = 0;

  localparam logic [7:0] CR = 8'd13;
  localparam logic [7:0] LF = 8'd10;

  ascii_dec_parse #(.WIDTH(12), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .val(val), .val_valid(val_valid),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one character, wait (bounded) for char_ready, and return #1 after
  // the accepting edge so outputs caused by that character are visible.
  task automatic send(input logic [7:0] c);
    int n = 0;
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clk);
    while (!char_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) begin
      errors++;
      $display("FAIL ready_timeout: observed char_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_val", 32'(val), 0);
    chk("rst_vv", 32'(val_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(char_ready), 1);

    // "123" CR back-to-back
    send("1");
    chk("busy_d1", 32'(busy), 1);
    send("2");
    send("3");
    chk("busy_d3", 32'(busy), 1);
    send(CR);
    chk("v123", 32'(val), 123);
    chk("vv123", 32'(val_valid), 1);
    chk("rdy_done", 32'(char_ready), 0);
    chk("busy_done", 32'(busy), 0);
    @(posedge clk); #1;
    chk("vv_pulse", 32'(val_valid), 0);
    chk("rdy_back", 32'(char_ready), 1);

    // leading zeros, then blank line
    send("0"); send("0"); send("7"); send(LF);
    chk("v007", 32'(val), 7);
    chk("vv007", 32'(val_valid), 1);
    @(posedge clk); #1;
    send(CR);
    chk("blank_vv", 32'(val_valid), 0);
    chk("blank_val", 32'(val), 7);
    chk("blank_busy", 32'(busy), 0);

    // too many digits
    send("4"); send("5"); send("6"); send("7");
    chk("long_err", 32'(err), 1);
    chk("long_busy", 32'(busy), 0);
    send(CR);
    chk("long_err_once", 32'(err), 0);
    chk("long_vv", 32'(val_valid), 0);
    chk("long_val", 32'(val), 7);
    send("9"); send(CR);
    chk("v9", 32'(val), 9);
    chk("vv9", 32'(val_valid), 1);
    @(posedge clk); #1;

    // illegal character, drained without further err
    send("1"); send("x");
    chk("ill_err", 32'(err), 1);
    send("2");
    chk("drain_err", 32'(err), 0);
    chk("drain_busy", 32'(busy), 0);
    send("-");
    chk("drain_err2", 32'(err), 0);
    send(CR);
    chk("drain_vv", 32'(val_valid), 0);
    chk("drain_val", 32'(val), 9);
    chk("drain_rdy", 32'(char_ready), 1);
    send("4"); send("2"); send(CR);
    chk("v42", 32'(val), 42);
    @(posedge clk); #1;

    // largest three-digit value
    send("9"); send("9"); send("9"); send(CR);
    chk("v999", 32'(val), 999);
    chk("vv999", 32'(val_valid), 1);
    @(posedge clk); #1;

    // reset mid-number
    send("5"); send("6");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_vv", 32'(val_valid), 0);
    send("8");
    chk("mid_rst_err2", 32'(err), 0);
    send(CR);
    chk("v8", 32'(val), 8);
    chk("vv8", 32'(val_valid), 1);
    @(posedge clk); #1;

`ifdef ASCII_PARSE_NEG_EN
    send("-"); send("1"); send("2"); send(CR);
    chk("vneg12", 32'(val), 32'h0FF4);
    chk("vvneg12", 32'(val_valid), 1);
    @(posedge clk); #1;
    send("-"); send(CR);
    chk("neg_empty_err", 32'(err), 1);
    chk("neg_empty_val", 32'(val), 32'h0FF4);
    chk("neg_empty_vv", 32'(val_valid), 0);
`else
    send("-");
    chk("minus_err", 32'(err), 1);
    send(CR);
    chk("minus_val", 32'(val), 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ascii_dec_parse.md
# ascii_dec_parse

Serial ASCII-decimal parser: accepts one 8-bit ASCII character per handshake, accumulates decimal digits into a WIDTH-bit unsigned binary value, and emits the value when a line terminator arrives. Sits between the character source (keypad/UART receive path) and the datapath that consumes 12-bit operands. It is the inverse of the three-digit value-to-LCD-ASCII conversion.

## Interface
- WIDTH, 12, bit width of the result value
- MAX_DIGITS, 3, maximum accepted digits per number (hundreds/tens/ones)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- char_in  in  8  ASCII character
- char_valid  in  1  char_in valid this cycle
- char_ready  out  1  parser can accept a character this cycle
- val  out  WIDTH  last successfully parsed value, held until the next success
- val_valid  out  1  one-cycle pulse: val just updated
- err  out  1  one-cycle pulse: malformed number detected
- busy  out  1  high while at least one digit of a number has been accepted (ACCUM)

## Operation
- Character accepted on a cycle with char_valid && char_ready; otherwise no state change.
- Digit = 8'd48..8'd57; terminator = CR 8'd13 or LF 8'd10; anything else is illegal.
- States: IDLE, ACCUM, DONE, DRAIN.
- IDLE: digit -> acc = digit, cnt = 1, ACCUM. Terminator -> ignored, stay IDLE (blank lines skipped). Illegal -> err pulse, DRAIN.
- ACCUM: digit with cnt < MAX_DIGITS -> acc = acc*10 + digit, cnt++. Digit with cnt == MAX_DIGITS -> err, DRAIN. Terminator -> val = acc, val_valid pulse, DONE. Illegal -> err, DRAIN.
- acc*10+digit computed in WIDTH+4 bits; result > 2^WIDTH-1 -> err, DRAIN (cannot occur with defaults, must still be implemented).
- Leading zeros count as digits ("007" = 7, 3 digits).
- DRAIN: discard all characters until a terminator is accepted, then IDLE; no further err pulses.
- DONE: lasts exactly one cycle, char_ready low, then IDLE.
- On error val is not modified.

## Timing
- Reset values: val = 0, val_valid = 0, err = 0, busy = 0, char_ready = 1, state IDLE, acc = 0, cnt = 0.
- rst asserted mid-number discards the partial acc; no val_valid or err generated.
- All outputs registered. Terminator accepted at edge N -> val/val_valid visible cycle after edge N, val_valid high exactly one cycle.
- err visible the cycle after the offending character is accepted, high exactly one cycle.
- char_ready = 0 only in DONE (one cycle per result) and during rst; otherwise 1. Sustained char_valid throughput: one char per cycle, plus one stall cycle after each terminator that completes a number.
- busy = 1 exactly while state is ACCUM.

## Configuration
- ASCII_PARSE_NEG_EN defined: a '-' (8'd45) accepted in IDLE only -> neg flag set, ACCUM with cnt = 0 (does not count as a digit). Terminator with cnt == 0 after '-' -> err, IDLE. On success val = two's complement negation of acc in WIDTH bits; magnitude limit for negative values is 2^(WIDTH-1), for positive 2^(WIDTH-1)-1, excess -> err, DRAIN. '-' anywhere else is illegal.
- ASCII_PARSE_NEG_EN undefined: '-' is illegal everywhere; val unsigned, limit 2^WIDTH-1; no neg flag logic synthesized.

## Test plan
- Reset, then "1","2","3",CR back-to-back -> val = 123, val_valid one cycle after CR accepted, char_ready low that cycle, busy high during digits.
- "0","0","7",LF -> val = 7; then CR alone -> no pulse, val stays 7.
- "4","5","6","7",CR -> err pulse after the 4th digit, no val_valid, val unchanged, next "9",CR -> val = 9.
- "1","x","2",CR -> err after 'x', remaining chars drained, then "42",CR -> val = 42.
- "5","6", rst for one cycle, "8",CR -> val = 8, no err pulse.
- With ASCII_PARSE_NEG_EN: "-","1","2",CR -> val = 12'hFF4; "-",CR -> err, val unchanged.
